text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer.sv | 104 ++++++++++
 tb/tb_text_renderer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_renderer.sv
// text_renderer: 80x30 text-mode pixel pipeline (char RAM -> font ROM -> palette)
// with blinking block cursor; 4-cycle latency from x/y/syncs to rgb/syncs.
module text_renderer #(
    parameter int BLINK_BIT   = 4,
    parameter int CURSOR_ROWS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        h_sync_i,
    input  logic        v_sync_i,
    output logic [11:0] char_addr,
    input  logic [15:0] char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] rgb_o,
    output logic        h_sync_o,
    output logic        v_sync_o
);

    logic        vis_d, cur_d, pix_d;
    logic [11:0] char_addr_d, font_addr_d, rgb_d;
    logic [7:0]  frame_cnt_d;
    logic [11:0] char_addr_q, font_addr_q, rgb_q;
    logic [7:0]  frame_cnt_q;
    logic        vs_prev_q, pix_q;
    logic [3:0]  hs_q, vs_q;
    logic [2:0]  vis_q;
    logic [1:0]  cur_q;
    logic [3:0]  grow_q, fg2_q, bg2_q, fg3_q, bg3_q;
    logic [2:0]  gcol1_q, gcol2_q;

    function automatic logic [11:0] palette(input logic [3:0] i);
        logic [3:0] on, off;
        on  = i[3] ? 4'hF : 4'hA;
        off = i[3] ? 4'h5 : 4'h0;
        return {i[2] ? on : off, i[1] ? on : off, i[0] ? on : off};
    endfunction

    always_comb begin
        vis_d       = (x_i < 10'd640) && (y_i < 10'd480);
        char_addr_d = vis_d ? 12'(y_i[8:4]) * 12'd80 + 12'(x_i[9:3]) : 12'd0;
        cur_d       = cursor_en && frame_cnt_q[BLINK_BIT] && vis_d &&
                      (cursor_col < 7'd80) && (cursor_row < 5'd30) &&
                      (cursor_col == x_i[9:3]) && (cursor_row == y_i[8:4]) &&
                      (5'(y_i[3:0]) >= 5'(16 - CURSOR_ROWS));
        font_addr_d = {char_data[7:0], grow_q};
        // cursor is folded into the pixel bit so it always selects fg
        pix_d       = font_data[~gcol2_q] | cur_q[1];
        rgb_d       = vis_q[2] ? palette(pix_q ? fg3_q : bg3_q) : 12'h000;
        frame_cnt_d = frame_cnt_q + 8'(vs_prev_q & ~v_sync_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_addr_q <= '0;
            font_addr_q <= '0;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
            vs_prev_q   <= 1'b1;
            hs_q        <= 4'hF;
            vs_q        <= 4'hF;
            vis_q       <= '0;
            cur_q       <= '0;
            pix_q       <= 1'b0;
            grow_q      <= '0;
            gcol1_q     <= '0;
            gcol2_q     <= '0;
            fg2_q       <= '0;
            bg2_q       <= '0;
            fg3_q       <= '0;
            bg3_q       <= '0;
        end else begin
            char_addr_q <= char_addr_d;
            font_addr_q <= font_addr_d;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
            vs_prev_q   <= v_sync_i;
            hs_q        <= {hs_q[2:0], h_sync_i};
            vs_q        <= {vs_q[2:0], v_sync_i};
            vis_q       <= {vis_q[1:0], vis_d};
            cur_q       <= {cur_q[0], cur_d};
            pix_q       <= pix_d;
            grow_q      <= y_i[3:0];
            gcol1_q     <= x_i[2:0];
            gcol2_q     <= gcol1_q;
            fg2_q       <= char_data[11:8];
            bg2_q       <= char_data[15:12];
            fg3_q       <= fg2_q;
            bg3_q       <= bg2_q;
        end
    end

    assign char_addr = char_addr_q;
    assign font_addr = font_addr_q;
    assign rgb_o     = rgb_q;
    assign h_sync_o  = hs_q[3];
    assign v_sync_o  = vs_q[3];

endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: transaction model of the text pipeline with bench-side RAM/ROM,
// per-cycle comparison plus directed literal vectors.
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x_i = 10'd700, y_i = 10'd500;
    logic        h_sync_i = 1'b1, v_sync_i = 1'b1;
    logic [11:0] char_addr, font_addr, rgb_o;
    logic [15:0] char_data;
    logic [7:0]  font_data;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = 7'd0;
    logic [4:0]  cursor_row = 5'd0;
    logic        h_sync_o, v_sync_o;

    logic        mode = 1'b0;
    logic [15:0] cconst = 16'h0;
    logic [7:0]  fconst = 8'h0;
    int          checks = 0, fails = 0;
    bit          armed = 1'b0;

    text_renderer dut (
        .clk(clk), .rst_n(rst_n), .x_i(x_i), .y_i(y_i),
        .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb_o(rgb_o), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o)
    );

    always #20 clk = ~clk;

    function automatic logic [15:0] chash(input logic [11:0] a);
        return {a[3:0] ^ 4'h9, a[7:4] ^ a[11:8], a[7:0] ^ 8'h5A};
    endfunction

    function automatic logic [7:0] fhash(input logic [11:0] a);
        return (a[7:0] * 8'd37) ^ {a[11:8], a[11:8]};
    endfunction

    always_comb char_data = mode ? cconst : chash(char_addr);
    always_comb font_data = mode ? fconst : fhash(font_addr);

    function automatic logic [11:0] colour(input logic [3:0] i);
        logic [11:0] c;
        c = '0;
        for (int k = 0; k < 3; k++) c[k*4 +: 4] = 4'((i[k] ? 10 : 0) + (i[3] ? 5 : 0));
        return c;
    endfunction

    typedef struct {
        logic [11:0] ca, fa, rgb;
        logic        hs, vs, vis, cur, on;
        logic [3:0]  gr, fg, bg;
        logic [2:0]  gc;
    } ent_t;

    ent_t        p [1:4];
    ent_t        n;
    logic [7:0]  fc;
    bit          vp;
    logic [15:0] md;
    logic [7:0]  mf;

    function automatic ent_t idle_ent();
        ent_t e;
        e.ca = 0; e.fa = 0; e.rgb = 0; e.hs = 1; e.vs = 1; e.vis = 0;
        e.cur = 0; e.on = 0; e.gr = 0; e.fg = 0; e.bg = 0; e.gc = 0;
        return e;
    endfunction

    // model: each pixel is a transaction aging one slot per clock; memories answer
    // at the age the addressing rules say they are read
    always @(posedge clk) begin
        armed = 1'b1;
        if (!rst_n) begin
            for (int i = 1; i <= 4; i++) p[i] = idle_ent();
            fc = 0;
            vp = 1;
        end else begin
            n = p[3];
            n.rgb = p[3].vis ? colour((p[3].on || p[3].cur) ? p[3].fg : p[3].bg) : 12'h000;
            p[4] = n;
            n = p[2];
            mf = mode ? fconst : fhash(p[2].fa);
            n.on = mf[7 - int'(p[2].gc)];
            p[3] = n;
            n = p[1];
            md = mode ? cconst : chash(p[1].ca);
            n.fg = md[11:8];
            n.bg = md[15:12];
            n.fa = {md[7:0], p[1].gr};
            p[2] = n;
            n = idle_ent();
            n.vis = (x_i < 640) && (y_i < 480);
            n.ca  = n.vis ? 12'((y_i / 16) * 80 + x_i / 8) : 12'd0;
            n.gr  = 4'(y_i % 16);
            n.gc  = 3'(x_i % 8);
            n.hs  = h_sync_i;
            n.vs  = v_sync_i;
            n.cur = cursor_en && ((fc / 16) % 2 == 1) && n.vis && cursor_col < 80 &&
                    cursor_row < 30 && cursor_col == x_i / 8 && cursor_row == y_i / 16 &&
                    (y_i % 16) >= 14;
            p[1] = n;
            if (vp && !v_sync_i) fc = fc + 8'd1;
            vp = v_sync_i;
        end
    end

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_char_addr", char_addr, p[1].ca);
            chk("model_font_addr", font_addr, p[2].fa);
            chk("model_rgb", rgb_o, p[4].rgb);
            chk("model_hsync", 12'(h_sync_o), 12'(p[4].hs));
            chk("model_vsync", 12'(v_sync_o), 12'(p[4].vs));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int x, input int y);
        x_i = 10'(x);
        y_i = 10'(y);
    endtask

    task automatic pix_lit(input int x, input int y, input logic [11:0] e, input string nm);
        drv(x, y);
        tick();
        drv(700, 500);
        repeat (3) tick();
        chk(nm, rgb_o, e);
    endtask

    task automatic vpulse();
        v_sync_i = 1'b0;
        tick();
        v_sync_i = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_rgb", rgb_o, 12'h000);
        chk("reset_hsync", 12'(h_sync_o), 12'd1);
        chk("reset_vsync", 12'(v_sync_o), 12'd1);
        chk("reset_char_addr", char_addr, 12'd0);
        chk("reset_font_addr", font_addr, 12'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        mode = 1'b1; cconst = 16'h7F41; fconst = 8'h80;
        repeat (4) tick();
        drv(0, 0);
        tick();
        chk("origin_char_addr", char_addr, 12'd0);
        drv(8, 16);
        tick();
        chk("origin_font_addr", font_addr, 12'h410);
        chk("cell_1_1_char_addr", char_addr, 12'd81);
        drv(700, 500);
        tick();
        tick();
        chk("origin_rgb", rgb_o, 12'hFFF);

        fconst = 8'h01;
        repeat (4) tick();
        drv(638, 479);
        tick();
        chk("last_cell_addr_a", char_addr, 12'd2399);
        drv(639, 479);
        tick();
        chk("last_cell_addr_b", char_addr, 12'd2399);
        drv(640, 479);
        tick();
        chk("x640_char_addr", char_addr, 12'd0);
        drv(700, 500);
        tick();
        chk("gcol6_bg_rgb", rgb_o, 12'hAAA);
        tick();
        chk("gcol7_bit0_rgb", rgb_o, 12'hFFF);
        tick();
        chk("x640_blank_rgb", rgb_o, 12'h000);

        mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drv($urandom_range(0, 720), $urandom_range(0, 520));
            h_sync_i = ($urandom_range(0, 7) != 0);
            tick();
        end
        for (int x = 600; x < 660; x++) begin
            drv(x, 479);
            tick();
        end
        h_sync_i = 1'b1;
        drv(700, 500);
        repeat (4) tick();

        h_sync_i = 1'b0;
        tick();
        tick();
        h_sync_i = 1'b1;
        tick();
        chk("hsync_pre", 12'(h_sync_o), 12'd1);
        tick();
        chk("hsync_low_a", 12'(h_sync_o), 12'd0);
        tick();
        chk("hsync_low_b", 12'(h_sync_o), 12'd0);
        tick();
        chk("hsync_post", 12'(h_sync_o), 12'd1);
        v_sync_i = 1'b0;
        tick();
        v_sync_i = 1'b1;
        tick();
        tick();
        chk("vsync_pre", 12'(v_sync_o), 12'd1);
        tick();
        chk("vsync_low", 12'(v_sync_o), 12'd0);
        tick();
        chk("vsync_post", 12'(v_sync_o), 12'd1);

        for (int x = 0; x < 32; x++) begin
            drv(x, 100);
            if (x == 15) rst_n = 1'b0;
            tick();
            if (x == 15) begin
                chk("midline_reset_rgb", rgb_o, 12'h000);
                chk("midline_reset_char_addr", char_addr, 12'd0);
                chk("midline_reset_font_addr", font_addr, 12'd0);
                chk("midline_reset_hsync", 12'(h_sync_o), 12'd1);
                rst_n = 1'b1;
            end
        end
        drv(700, 500);
        repeat (4) tick();

        mode = 1'b1; cconst = 16'h1F00; fconst = 8'h00;
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd3;
        repeat (4) tick();
        for (int fr = 0; fr <= 40; fr++) begin
            pix_lit(40, 62, (fr >= 16 && fr <= 31) ? 12'hFFF : 12'h00A, "cursor_blink");
            if (fr == 16) begin
                pix_lit(47, 63, 12'hFFF, "cursor_corner");
                pix_lit(40, 61, 12'h00A, "above_cursor");
                pix_lit(48, 62, 12'h00A, "right_of_cursor");
                pix_lit(39, 62, 12'h00A, "left_of_cursor");
            end
            if (fr == 20) begin
                cursor_col = 7'd85;
                pix_lit(40, 62, 12'h00A, "cursor_col_out_of_range");
                cursor_col = 7'd5;
                cursor_en = 1'b0;
                pix_lit(40, 62, 12'h00A, "cursor_disabled");
                cursor_en = 1'b1;
            end
            if (fr < 40) vpulse();
        end
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
